// File: rtl/cover_toggle_sched_pkg.sv
// cover_pkg: shared types and helpers for the toggle-coverage scheduler.
//   COVER_TOTAL - total cover points design-wide (group index range bound)
//   IDX_W       - width of an emitted absolute cover index
//   cover_idx_t - absolute cover index type
//   popcount    - population count of up to 64 bits
//   clog2       - ceil(log2(v)), usable in parameter expressions
package cover_pkg;

  localparam int COVER_TOTAL = 38253;
  localparam int IDX_W       = 64;

  typedef logic [IDX_W-1:0] cover_idx_t;

  function automatic logic [6:0] popcount(input logic [63:0] v);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < 64; i++) c = c + 7'(v[i]);
    return c;
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/cover_toggle_sched_if.sv
// cover_toggle_sched_if: report channel toward the coverage export sink.
//   out_valid - out_index holds a report          (master -> slave)
//   out_index - absolute cover index               (master -> slave)
//   out_ready - sink accepts the current report    (slave -> master)
interface cover_toggle_sched_if;
  logic                 out_valid;
  logic                 out_ready;
  cover_pkg::cover_idx_t out_index;

  modport master (output out_valid, output out_index, input out_ready);
  modport slave  (input out_valid, input out_index, output out_ready);
endinterface

// File: rtl/cover_toggle_sched_prio_enc.sv
// cover_prio_enc: lowest-set-bit encoder.
//   req - request vector
//   gnt - one-hot of the lowest set bit of req (zero when req == 0)
//   idx - binary position of that bit (zero when req == 0)
//   any - req != 0
module cover_prio_enc #(
  parameter int W  = 12,
  parameter int SW = 4
) (
  input  logic [W-1:0]  req,
  output logic [W-1:0]  gnt,
  output logic [SW-1:0] idx,
  output logic          any
);
  always_comb begin
    // two's-complement trick isolates the lowest set bit
    gnt = req & (~req + W'(1));
    any = |req;
    idx = '0;
    // scan downward so the lowest set bit is the last one written
    for (int i = W - 1; i >= 0; i--)
      if (req[i]) idx = SW'(i);
  end
endmodule

// File: rtl/cover_toggle_sched.sv
// cover_toggle_sched: records first hits of W toggle cover points, queues them
// as pending and drains them one per cycle, lowest bit first, as absolute
// cover indices (COVER_INDEX + bit) over a valid/ready channel.
//   clock, reset  - rising-edge clock, synchronous active-high reset
//   enable        - hits on valid are accepted only when 1
//   valid[W]      - per-point hit vector, sampled every cycle
//   clear         - one-cycle pulse, forgets covered history
//   out_ch        - report channel (cover_toggle_sched_if.master)
//   covered_cnt   - number of distinct points covered since clear/reset
//   all_covered   - covered_cnt == W
//   coalesce_cnt  - saturating count of hits landing on an already-pending bit
// Build option: COVER_TOGGLE_DEDUP_EN
//   defined   - a point reports at most once between clears
//   undefined - covered history is tracked but not used to filter hits
// COVER_INDEX + W is expected to stay within cover_pkg::COVER_TOTAL.
module cover_toggle_sched
  import cover_pkg::*;
#(
  parameter int W           = 12,
  parameter int COVER_INDEX = 0,
  parameter int CNT_W       = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [W-1:0]            valid,
  input  logic                    clear,
  cover_toggle_sched_if.master    out_ch,
  output logic [clog2(W+1)-1:0]   covered_cnt,
  output logic                    all_covered,
  output logic [CNT_W-1:0]        coalesce_cnt
);
  localparam int CW = clog2(W + 1);
  localparam int SW = (W > 1) ? clog2(W) : 1;

  logic [W-1:0]     pending, covered;
  logic [W-1:0]     cov_hist, cov_filt, hits_new, cand, gnt, gnt_eff, coal_hits;
  logic [SW-1:0]    sel;
  logic             any, load;
  logic             out_valid_q;
  cover_idx_t       out_index_q;
  logic [CNT_W+7:0] coal_sum;
  logic [CNT_W-1:0] coal_next;

  // history as seen this cycle: a clear pulse makes it empty immediately
  assign cov_hist = clear ? '0 : covered;
`ifdef COVER_TOGGLE_DEDUP_EN
  assign cov_filt = cov_hist;
`else
  assign cov_filt = '0;
`endif
  assign hits_new = enable ? (valid & ~cov_filt) : '0;
  assign cand     = pending | hits_new;

  cover_prio_enc #(.W(W), .SW(SW)) u_enc (
    .req (cand),
    .gnt (gnt),
    .idx (sel),
    .any (any)
  );

  // a stalled output register grants nothing, so every candidate stays pending
  assign load    = !out_valid_q || out_ch.out_ready;
  assign gnt_eff = load ? gnt : '0;

  assign coal_hits = enable ? (valid & pending) : '0;
  assign coal_sum  = {8'b0, coalesce_cnt} + (CNT_W + 8)'(popcount(64'(coal_hits)));
  assign coal_next = (|coal_sum[CNT_W+7:CNT_W]) ? '1 : coal_sum[CNT_W-1:0];

  assign covered_cnt = CW'(popcount(64'(covered)));
  assign all_covered = (covered_cnt == CW'(W));

  assign out_ch.out_valid = out_valid_q;
  assign out_ch.out_index = out_index_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      pending      <= '0;
      covered      <= '0;
      out_valid_q  <= 1'b0;
      out_index_q  <= '0;
      coalesce_cnt <= '0;
    end else begin
      pending      <= cand & ~gnt_eff;
      covered      <= cov_hist | hits_new;
      coalesce_cnt <= coal_next;
      if (load) begin
        out_valid_q <= any;
        // index holds when the queue runs dry
        if (any) out_index_q <= cover_idx_t'(COVER_INDEX) + cover_idx_t'(sel);
      end
    end
  end

endmodule

// File: tb/tb_cover_toggle_sched.sv
module tb_cover_toggle_sched;
  import cover_pkg::*;

  localparam int W  = 12;
  localparam int CI = 100;
`ifdef COVER_TOGGLE_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset, enable, clear;
  logic [W-1:0]  valid;
  logic [3:0]    covered_cnt;
  logic          all_covered;
  logic [15:0]   coalesce_cnt;
  int            n_run  = 0;
  int            n_fail = 0;

  cover_toggle_sched_if ch ();

  cover_toggle_sched #(.W(W), .COVER_INDEX(CI), .CNT_W(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .valid        (valid),
    .clear        (clear),
    .out_ch       (ch),
    .covered_cnt  (covered_cnt),
    .all_covered  (all_covered),
    .coalesce_cnt (coalesce_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // advance one edge, then look 1 time unit later
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b1; clear = 1'b0; valid = '0; ch.out_ready = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int nrep;

    // reset state
    do_reset();
    chk("rst_valid", 64'(ch.out_valid), 64'd0);
    chk("rst_index", ch.out_index, 64'd0);
    chk("rst_cov", 64'(covered_cnt), 64'd0);
    chk("rst_all", 64'(all_covered), 64'd0);
    chk("rst_coal", 64'(coalesce_cnt), 64'd0);

    // enable=0 ignores hits completely
    enable = 1'b0; valid = 12'hFFF; tick();
    chk("dis_valid", 64'(ch.out_valid), 64'd0);
    chk("dis_cov", 64'(covered_cnt), 64'd0);
    enable = 1'b1; valid = '0;

    // single hit with idle output: report next cycle
    valid = 12'h004; tick(); valid = '0;
    chk("one_valid", 64'(ch.out_valid), 64'd1);
    chk("one_index", ch.out_index, 64'd102);
    chk("one_cov", 64'(covered_cnt), 64'd1);
    tick();
    chk("one_drain", 64'(ch.out_valid), 64'd0);
    chk("one_hold_idx", ch.out_index, 64'd102);

    // burst with backpressure: 100 held, then 104, 111
    do_reset();
    ch.out_ready = 1'b0; valid = 12'h811; tick(); valid = '0;
    chk("bp_idx0", ch.out_index, 64'd100);
    tick();
    chk("bp_hold1", ch.out_index, 64'd100);
    tick();
    chk("bp_hold2_v", 64'(ch.out_valid), 64'd1);
    chk("bp_hold2", ch.out_index, 64'd100);
    ch.out_ready = 1'b1; tick();
    chk("bp_idx1", ch.out_index, 64'd104);
    tick();
    chk("bp_idx2", ch.out_index, 64'd111);
    tick();
    chk("bp_end", 64'(ch.out_valid), 64'd0);
    chk("bp_cov", 64'(covered_cnt), 64'd3);

    // repeated hit on one point, sink ready: one report with dedup, five without
    do_reset();
    nrep = 0;
    valid = 12'h001;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) valid = '0;
      tick();
      if (ch.out_valid) nrep++;
    end
    chk("dd_reports", 64'(nrep), DEDUP ? 64'd1 : 64'd5);
    chk("dd_coal", 64'(coalesce_cnt), 64'd0);

    // same hit, sink stalled: without dedup the bit becomes pending on the
    // 2nd cycle (1st was granted) and coalesces on cycles 3..5 -> 3
    do_reset();
    ch.out_ready = 1'b0; valid = 12'h001;
    for (int i = 0; i < 5; i++) tick();
    valid = '0;
    chk("dd_stall_coal", 64'(coalesce_cnt), DEDUP ? 64'd0 : 64'd3);
    chk("dd_stall_idx", ch.out_index, 64'd100);

    // full coverage: 100..111 ascending
    do_reset();
    valid = 12'hFFF; tick(); valid = '0;
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("full_v%0d", k), 64'(ch.out_valid), 64'd1);
      chk($sformatf("full_i%0d", k), ch.out_index, 64'(CI + k));
      if (k < 11) tick();
    end
    chk("full_all", 64'(all_covered), 64'd1);
    chk("full_cnt", 64'(covered_cnt), 64'd12);
    tick();
    chk("full_end", 64'(ch.out_valid), 64'd0);
    valid = 12'hFFF; tick(); valid = '0;
    chk("full_rep_v", 64'(ch.out_valid), DEDUP ? 64'd0 : 64'd1);

    // clear on the 2nd report cycle with a fresh hit on bit 0: the queued
    // reports survive and the new bit 0 wins on ascending order
    do_reset();
    valid = 12'h00F; tick(); valid = '0;
    chk("clr_r0", ch.out_index, 64'd100);
    tick();
    chk("clr_r1", ch.out_index, 64'd101);
    clear = 1'b1; valid = 12'h001; tick(); clear = 1'b0; valid = '0;
    chk("clr_r2", ch.out_index, 64'd100);
    tick();
    chk("clr_r3", ch.out_index, 64'd102);
    tick();
    chk("clr_r4", ch.out_index, 64'd103);
    tick();
    chk("clr_end", 64'(ch.out_valid), 64'd0);
    chk("clr_cov", 64'(covered_cnt), 64'd1);

    // reset mid-operation: pending 0F0 behind a stalled report
    do_reset();
    ch.out_ready = 1'b0; valid = 12'h001; tick();
    valid = 12'h0F0; tick();
    tick();
    valid = '0;
    chk("rm_coal", 64'(coalesce_cnt), 64'd4);
    chk("rm_v", 64'(ch.out_valid), 64'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rm_valid", 64'(ch.out_valid), 64'd0);
    chk("rm_cov", 64'(covered_cnt), 64'd0);
    chk("rm_coal0", 64'(coalesce_cnt), 64'd0);
    ch.out_ready = 1'b1;
    nrep = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ch.out_valid) nrep++;
    end
    chk("rm_quiet", 64'(nrep), 64'd0);

    // coalesce saturates at all-ones (>= 11 merges per cycle for 6000 cycles)
    do_reset();
    ch.out_ready = 1'b0; valid = 12'hFFF;
    for (int i = 0; i < 6000; i++) tick();
    valid = '0;
    chk("coal_sat", 64'(coalesce_cnt), 64'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
